pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Parametrised hazard, forwarding and flush controller for the in-order RISC-V pipeline. It replaces the fixed 3-stage ad-hoc forwarding selects with a generalised scoreboard: a shift register of in-flight destination records over DEPTH post-decode stages. It sits beside the decode stage and drives forwarding-mux selects, decode stall, X-stage bubble and decode flush. It also keeps saturating hazard and flush counters for the CSR/perf path.

Parameters:
DEPTH, 2, number of tracked post-decode stages (entry 0 = X, entry DEPTH-1 = oldest/WB); legal range 1..7
RA_W, 5, register address width
LOAD_STAGE, 1, lowest entry index whose load result is forwardable; legal range 0..DEPTH-1
CNT_W, 16, width of each perf counter
FSW, $clog2(DEPTH+1), forwarding select width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
d_valid  in  1  decode holds a valid instruction
d_rs1  in  RA_W  decode source 1 index
d_rs2  in  RA_W  decode source 2 index
d_rs1_used  in  1  instruction reads rs1
d_rs2_used  in  1  instruction reads rs2
d_rd  in  RA_W  decode destination index
d_we  in  1  instruction writes rd
d_is_load  in  1  instruction is a load
mem_stall  in  1  cache stall; freezes the whole pipeline
redirect  in  1  taken branch/jump resolved in X (entry 0)
cnt_clr  in  1  synchronous clear of both counters
fwd_sel_a  out  FSW  0 = regfile; k = forward from entry k-1
fwd_sel_b  out  FSW  same encoding for rs2
stall_d  out  1  hold PC and IF/ID register
bubble_x  out  1  load a NOP into entry 0 / ID-X registers
flush_d  out  1  kill the instruction in decode
pipe_en  out  1  global advance enable
stg_valid  out  DEPTH  per-entry valid
stg_rd  out  DEPTH*RA_W  per-entry rd; entry k at bits [k*RA_W +: RA_W]
hazard_cnt  out  CNT_W  load-use stall cycles
flush_cnt  out  CNT_W  redirect flushes

Behaviour:
- Reset (reset=0, asynchronous): all entry valid/we/is_load bits = 0, rd fields = 0, both counters = 0. With these entries the combinational outputs evaluate to fwd_sel = 0, stall_d = 0, bubble_x = 0, flush_d = 0 (while redirect = 0), and pipe_en = !mem_stall.
- pipe_en = !mem_stall (combinational).
- A match for source s on entry k requires: s_used, s != 0, and entry k has valid & we & rd == s. x0 is never forwarded and never causes a hazard.
- Priority is youngest first: the lowest k that matches wins.
- If the winning entry is a load and k < LOAD_STAGE, a load-use hazard is raised and fwd_sel = 0. Otherwise fwd_sel = k+1. With no match, fwd_sel = 0.
- flush_d = redirect & pipe_en.
- stall_d = d_valid & (hazard on rs1 or rs2) & !flush_d & pipe_en. Redirect beats load-use.
- bubble_x = pipe_en & (stall_d | flush_d | !d_valid).
- All selects are combinational from current entries and decode inputs. There is zero-cycle latency to the datapath muxes.
- Shift, only when pipe_en = 1:
  - entry[k] <= entry[k-1] for k >= 1.
  - entry[0] <= {d_valid, d_we, d_is_load, d_rd} when bubble_x = 0; otherwise entry[0] <= all-zero bubble.
- When pipe_en = 0: entries, counters and outputs derived from entries all hold. Requests from the previous cycle are re-evaluated combinationally.
- Counters:
  - hazard_cnt += 1 on each cycle with stall_d = 1.
  - flush_cnt += 1 on each cycle with flush_d = 1.
  - Both saturate at 2^CNT_W - 1 and never wrap.
  - cnt_clr has priority over increment; the counter reads 0 on the next cycle.
- Redirect does not invalidate entry 0. The branch in X retires normally; only decode is killed.
- Reset mid-operation discards all entries immediately. The first cycle after release behaves as an empty pipeline.
- d_valid = 0 with any other inputs produces a bubble in entry 0 and no stall.

Test Plan:
1. Hold reset=0 then release, d_valid=0 for 3 cycles -> stg_valid=0, fwd_sel_a/b=0, stall_d=0, bubble_x=1, both counters 0.
2. DEPTH=2: issue add x5 (d_we=1), next cycle add rs1=x5 -> fwd_sel_a=1; with an unrelated instruction in between instead -> fwd_sel_a=2.
3. lw x6, then next cycle add rs2=x6 -> stall_d=1 and bubble_x=1 for exactly 1 cycle, hazard_cnt=1; following cycle fwd_sel_b=2, stall_d=0.
4. Entry 0 rd=x0 we=1, decode rs1=x0 used -> fwd_sel_a=0, stall_d=0; entries 0 and 1 both rd=x7, decode rs1=x7 -> fwd_sel_a=1.
5. Load-use pending plus mem_stall=1 for 3 cycles -> pipe_en=0, stall_d=0, stg_valid/stg_rd frozen, hazard_cnt unchanged; on release the stall is taken once.
6. Load-use hazard and redirect=1 in the same cycle -> flush_d=1, stall_d=0, flush_cnt+1, hazard_cnt unchanged. Preload the counter near all-ones via 2^CNT_W-1 events -> it stays at 0xFFFF; then cnt_clr -> 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based hazard, forwarding and flush controller for the in-order pipeline.
// Tracks in-flight destinations across DEPTH post-decode stages (entry 0 = X).
module pipe_hazard_ctrl #(
  parameter int DEPTH      = 2,
  parameter int RA_W       = 5,
  parameter int LOAD_STAGE = 1,
  parameter int CNT_W      = 16,
  parameter int FSW        = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    d_valid,
  input  logic [RA_W-1:0]         d_rs1,
  input  logic [RA_W-1:0]         d_rs2,
  input  logic                    d_rs1_used,
  input  logic                    d_rs2_used,
  input  logic [RA_W-1:0]         d_rd,
  input  logic                    d_we,
  input  logic                    d_is_load,
  input  logic                    mem_stall,
  input  logic                    redirect,
  input  logic                    cnt_clr,
  output logic [FSW-1:0]          fwd_sel_a,
  output logic [FSW-1:0]          fwd_sel_b,
  output logic                    stall_d,
  output logic                    bubble_x,
  output logic                    flush_d,
  output logic                    pipe_en,
  output logic [DEPTH-1:0]        stg_valid,
  output logic [DEPTH*RA_W-1:0]   stg_rd,
  output logic [CNT_W-1:0]        hazard_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  logic [DEPTH-1:0]      r_vld;
  logic [DEPTH-1:0]      r_we;
  logic [DEPTH-1:0]      r_ld;
  logic [DEPTH*RA_W-1:0] r_rd;
  logic [CNT_W-1:0]      r_hazard_cnt;
  logic [CNT_W-1:0]      r_flush_cnt;

  logic [FSW:0]          w_res_a;
  logic [FSW:0]          w_res_b;
  logic                  w_pipe_en;
  logic                  w_flush;
  logic                  w_haz;
  logic                  w_stall;
  logic                  w_bubble;

  // Returns {load_use_hazard, fwd_sel}. Scanning oldest to youngest lets the
  // youngest (lowest index) matching entry overwrite any older match.
  function automatic logic [FSW:0] resolve(
    input logic                  used,
    input logic [RA_W-1:0]       src,
    input logic [DEPTH-1:0]      vld,
    input logic [DEPTH-1:0]      we,
    input logic [DEPTH-1:0]      ld,
    input logic [DEPTH*RA_W-1:0] rd
  );
    logic [FSW-1:0] sel;
    logic           haz;
    sel = '0;
    haz = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (used && (src != '0) && vld[k] && we[k] && (rd[k*RA_W +: RA_W] == src)) begin
        haz = ld[k] && (k < LOAD_STAGE);
        sel = haz ? '0 : FSW'(k + 1);
      end
    end
    return {haz, sel};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  always_comb begin
    w_res_a   = resolve(d_rs1_used, d_rs1, r_vld, r_we, r_ld, r_rd);
    w_res_b   = resolve(d_rs2_used, d_rs2, r_vld, r_we, r_ld, r_rd);
    w_pipe_en = !mem_stall;
    w_flush   = redirect && w_pipe_en;
    w_haz     = w_res_a[FSW] || w_res_b[FSW];
    // A redirect kills decode, so a load-use stall on the dead instruction is moot.
    w_stall   = d_valid && w_haz && !w_flush && w_pipe_en;
    w_bubble  = w_pipe_en && (w_stall || w_flush || !d_valid);
  end

  assign fwd_sel_a  = w_res_a[FSW-1:0];
  assign fwd_sel_b  = w_res_b[FSW-1:0];
  assign pipe_en    = w_pipe_en;
  assign flush_d    = w_flush;
  assign stall_d    = w_stall;
  assign bubble_x   = w_bubble;
  assign stg_valid  = r_vld;
  assign stg_rd     = r_rd;
  assign hazard_cnt = r_hazard_cnt;
  assign flush_cnt  = r_flush_cnt;

  // Scoreboard shift; entry 0 takes the decode record or a zero bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
      r_we  <= '0;
      r_ld  <= '0;
      r_rd  <= '0;
    end else if (w_pipe_en) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        r_vld[k]                <= r_vld[k-1];
        r_we[k]                 <= r_we[k-1];
        r_ld[k]                 <= r_ld[k-1];
        r_rd[k*RA_W +: RA_W]    <= r_rd[(k-1)*RA_W +: RA_W];
      end
      if (w_bubble) begin
        r_vld[0]        <= 1'b0;
        r_we[0]         <= 1'b0;
        r_ld[0]         <= 1'b0;
        r_rd[0 +: RA_W] <= '0;
      end else begin
        r_vld[0]        <= d_valid;
        r_we[0]         <= d_we;
        r_ld[0]         <= d_is_load;
        r_rd[0 +: RA_W] <= d_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hazard_cnt <= '0;
      r_flush_cnt  <= '0;
    end else if (cnt_clr) begin
      r_hazard_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_stall) r_hazard_cnt <= sat_inc(r_hazard_cnt);
      if (w_flush) r_flush_cnt  <= sat_inc(r_flush_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl at default parameters (DEPTH=2, LOAD_STAGE=1).
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic        d_valid;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic        d_rs1_used;
  logic        d_rs2_used;
  logic [4:0]  d_rd;
  logic        d_we;
  logic        d_is_load;
  logic        mem_stall;
  logic        redirect;
  logic        cnt_clr;
  logic [1:0]  fwd_sel_a;
  logic [1:0]  fwd_sel_b;
  logic        stall_d;
  logic        bubble_x;
  logic        flush_d;
  logic        pipe_en;
  logic [1:0]  stg_valid;
  logic [9:0]  stg_rd;
  logic [15:0] hazard_cnt;
  logic [15:0] flush_cnt;

  int n_pass = 0;
  int n_total = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used), .d_rd(d_rd), .d_we(d_we),
    .d_is_load(d_is_load), .mem_stall(mem_stall), .redirect(redirect), .cnt_clr(cnt_clr),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall_d(stall_d), .bubble_x(bubble_x),
    .flush_d(flush_d), .pipe_en(pipe_en), .stg_valid(stg_valid), .stg_rd(stg_rd),
    .hazard_cnt(hazard_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic we, input logic ld);
    d_valid = v; d_rs1 = rs1; d_rs1_used = u1; d_rs2 = rs2; d_rs2_used = u2;
    d_rd = rd; d_we = we; d_is_load = ld;
    #1;
  endtask

  initial begin
    reset = 1'b0; mem_stall = 1'b0; redirect = 1'b0; cnt_clr = 1'b0;
    dec(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_valid", 32'(stg_valid), 0);
    chk("rst_rd", 32'(stg_rd), 0);
    chk("rst_hcnt", 32'(hazard_cnt), 0);
    chk("rst_fcnt", 32'(flush_cnt), 0);
    chk("rst_pipe_en", 32'(pipe_en), 1);
    step(); step();
    reset = 1'b1;

    // Empty pipeline with no valid decode
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_valid", 32'(stg_valid), 0);
      chk("idle_fwd_a", 32'(fwd_sel_a), 0);
      chk("idle_fwd_b", 32'(fwd_sel_b), 0);
      chk("idle_stall", 32'(stall_d), 0);
      chk("idle_bubble", 32'(bubble_x), 1);
    end
    chk("idle_hcnt", 32'(hazard_cnt), 0);
    chk("idle_fcnt", 32'(flush_cnt), 0);

    // ALU forwarding from entry 0 and entry 1
    dec(1, 1, 1, 2, 1, 5, 1, 0);
    chk("alu_nomatch", 32'(fwd_sel_a), 0);
    step();
    dec(1, 5, 1, 0, 0, 8, 1, 0);
    chk("fwd_e0_a", 32'(fwd_sel_a), 1);
    chk("fwd_e0_stall", 32'(stall_d), 0);
    chk("fwd_e0_bubble", 32'(bubble_x), 0);
    step();
    dec(1, 1, 1, 2, 1, 5, 1, 0);
    step();
    dec(1, 3, 1, 4, 1, 10, 1, 0);
    chk("unrel_a", 32'(fwd_sel_a), 0);
    step();
    dec(1, 5, 1, 0, 0, 11, 1, 0);
    chk("fwd_e1_a", 32'(fwd_sel_a), 2);
    chk("stg_rd_5_10", 32'(stg_rd), {22'd0, 5'd5, 5'd10});
    chk("stg_valid_11", 32'(stg_valid), 2'b11);
    step();

    // Load-use: lw x6 then consumer of x6
    dec(1, 1, 1, 0, 0, 6, 1, 1);
    chk("lw_nomatch", 32'(fwd_sel_a), 0);
    step();
    dec(0, 1, 1, 6, 1, 12, 1, 0);
    chk("dv0_stall", 32'(stall_d), 0);
    chk("dv0_bubble", 32'(bubble_x), 1);
    dec(1, 1, 1, 6, 1, 12, 1, 0);
    chk("lu_stall", 32'(stall_d), 1);
    chk("lu_bubble", 32'(bubble_x), 1);
    chk("lu_fwd_b", 32'(fwd_sel_b), 0);
    chk("lu_hcnt_pre", 32'(hazard_cnt), 0);
    step();
    chk("lu_hcnt", 32'(hazard_cnt), 1);
    chk("lu_stall_done", 32'(stall_d), 0);
    chk("lu_fwd_b_e1", 32'(fwd_sel_b), 2);
    chk("lu_bubble_done", 32'(bubble_x), 0);
    chk("lu_valid_10", 32'(stg_valid), 2'b10);
    step();

    // x0 never forwarded; youngest of two matches wins
    dec(1, 1, 1, 2, 1, 0, 1, 0);
    step();
    dec(1, 0, 1, 0, 1, 7, 1, 0);
    chk("x0_fwd_a", 32'(fwd_sel_a), 0);
    chk("x0_fwd_b", 32'(fwd_sel_b), 0);
    chk("x0_stall", 32'(stall_d), 0);
    step();
    dec(1, 1, 1, 2, 1, 7, 1, 0);
    step();
    dec(1, 7, 1, 0, 0, 13, 1, 0);
    chk("youngest_a", 32'(fwd_sel_a), 1);
    step();

    // Load-use held under mem_stall for 3 cycles
    dec(1, 1, 1, 0, 0, 6, 1, 1);
    step();
    mem_stall = 1'b1;
    dec(1, 1, 1, 6, 1, 14, 1, 0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      chk("ms_pipe_en", 32'(pipe_en), 0);
      chk("ms_stall", 32'(stall_d), 0);
      chk("ms_bubble", 32'(bubble_x), 0);
      chk("ms_valid", 32'(stg_valid), 2'b11);
      chk("ms_rd", 32'(stg_rd), {22'd0, 5'd13, 5'd6});
      chk("ms_hcnt", 32'(hazard_cnt), 1);
    end
    mem_stall = 1'b0;
    #1;
    chk("ms_rel_stall", 32'(stall_d), 1);
    chk("ms_rel_bubble", 32'(bubble_x), 1);
    step();
    chk("ms_rel_hcnt", 32'(hazard_cnt), 2);
    chk("ms_rel_stall2", 32'(stall_d), 0);
    chk("ms_rel_fwd_b", 32'(fwd_sel_b), 2);
    step();

    // Redirect beats load-use
    dec(1, 1, 1, 0, 0, 6, 1, 1);
    step();
    redirect = 1'b1;
    dec(1, 6, 1, 0, 0, 15, 1, 0);
    chk("rd_flush", 32'(flush_d), 1);
    chk("rd_stall", 32'(stall_d), 0);
    chk("rd_bubble", 32'(bubble_x), 1);
    chk("rd_fcnt_pre", 32'(flush_cnt), 0);
    step();
    chk("rd_fcnt", 32'(flush_cnt), 1);
    chk("rd_hcnt", 32'(hazard_cnt), 2);
    chk("rd_e1_load_kept", 32'(stg_valid), 2'b10);

    // Saturate flush counter
    dec(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_max", 32'(flush_cnt), 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_hold", 32'(flush_cnt), 16'hFFFF);
    cnt_clr = 1'b1;
    step();
    chk("clr_fcnt", 32'(flush_cnt), 0);
    chk("clr_hcnt", 32'(hazard_cnt), 0);
    cnt_clr = 1'b0;
    redirect = 1'b0;

    // Asynchronous reset mid-operation
    dec(1, 1, 1, 2, 1, 20, 1, 0);
    step(); step();
    chk("pre_rst_valid", 32'(stg_valid), 2'b11);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(stg_valid), 0);
    chk("mid_rst_rd", 32'(stg_rd), 0);
    step();
    reset = 1'b1;
    dec(1, 20, 1, 0, 0, 21, 1, 0);
    chk("post_rst_fwd", 32'(fwd_sel_a), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
